// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control sequencer:
// FSM states, ALU op codes, opcode/funct constants and the control bundle.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_t;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluSlt = 3'b100
  } alu_op_t;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnSll = 6'b000000;
  localparam logic [5:0] FnSrl = 6'b000010;
  localparam logic [5:0] FnJr  = 6'b001000;

  // Wide enough for a MEM timeout of up to 255 cycles.
  localparam int unsigned MemCntW = 8;

  typedef struct packed {
    logic    ri;
    logic    lw;
    logic    shift;
    logic    srl;
    logic    jal;
    logic    jr;
    logic    jjrjal;
    logic    wr_reg;
    logic    store;
    logic    mem;
    logic    beq;
    logic    bne;
    alu_op_t op;
  } ctrl_t;

  localparam ctrl_t CtrlNone = '0;

endpackage

// File: rtl/cpu_decoder.sv
// Combinational opcode/funct decoder producing the datapath control bundle
// and an illegal-encoding flag.
module cpu_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o    = CtrlNone;
    illegal_o = 1'b0;
    case (opcode_i)
      OpRtype: begin
        case (funct_i)
          FnAdd: begin ctrl_o.wr_reg = 1'b1; ctrl_o.op = AluAdd; end
          FnSub: begin ctrl_o.wr_reg = 1'b1; ctrl_o.op = AluSub; end
          FnAnd: begin ctrl_o.wr_reg = 1'b1; ctrl_o.op = AluAnd; end
          FnOr:  begin ctrl_o.wr_reg = 1'b1; ctrl_o.op = AluOr;  end
          FnSlt: begin ctrl_o.wr_reg = 1'b1; ctrl_o.op = AluSlt; end
          FnSll: begin ctrl_o.wr_reg = 1'b1; ctrl_o.shift = 1'b1; end
          FnSrl: begin
            ctrl_o.wr_reg = 1'b1;
            ctrl_o.shift  = 1'b1;
            ctrl_o.srl    = 1'b1;
          end
          FnJr:  begin ctrl_o.jjrjal = 1'b1; ctrl_o.jr = 1'b1; end
          default: illegal_o = 1'b1;
        endcase
      end
      OpAddi: begin ctrl_o.ri = 1'b1; ctrl_o.wr_reg = 1'b1; ctrl_o.op = AluAdd; end
      OpAndi: begin ctrl_o.ri = 1'b1; ctrl_o.wr_reg = 1'b1; ctrl_o.op = AluAnd; end
      OpOri:  begin ctrl_o.ri = 1'b1; ctrl_o.wr_reg = 1'b1; ctrl_o.op = AluOr;  end
      OpLw: begin
        ctrl_o.ri     = 1'b1;
        ctrl_o.lw     = 1'b1;
        ctrl_o.wr_reg = 1'b1;
        ctrl_o.mem    = 1'b1;
        ctrl_o.op     = AluAdd;
      end
      OpSw: begin
        ctrl_o.ri    = 1'b1;
        ctrl_o.store = 1'b1;
        ctrl_o.mem   = 1'b1;
        ctrl_o.op    = AluAdd;
      end
      OpBeq: begin ctrl_o.beq = 1'b1; ctrl_o.op = AluSub; end
      OpBne: begin ctrl_o.bne = 1'b1; ctrl_o.op = AluSub; end
      OpJ:   ctrl_o.jjrjal = 1'b1;
      OpJal: begin ctrl_o.jjrjal = 1'b1; ctrl_o.jal = 1'b1; ctrl_o.wr_reg = 1'b1; end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS datapath.
// Optional single-step input enabled by defining CPU_SEQ_STEP_EN.
module cpu_seq_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MemTimeout = 16,
  parameter int unsigned CntW       = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            run_i,
`ifdef CPU_SEQ_STEP_EN
  input  logic            step_i,
`endif
  input  logic [5:0]      opcode_i,
  input  logic [5:0]      funct_i,
  input  logic            zero_i,
  input  logic            mem_ready_i,
  output logic            jbeq_o,
  output logic            jjrjal_o,
  output logic            jal_o,
  output logic            jr_o,
  output logic            ri_o,
  output logic            lw_o,
  output logic            shift_o,
  output logic            srl_o,
  output logic            write_reg_o,
  output logic            write_mem_o,
  output logic [2:0]      op_o,
  output logic            pc_en_o,
  output logic            halted_o,
  output logic            illegal_o,
  output logic            bus_err_o,
  output logic [CntW-1:0] retired_o
);

  state_t               state_q, state_d;
  ctrl_t                ctrl_q, ctrl_d, dec_ctrl, sel;
  logic                 dec_illegal;
  logic                 zero_q, zero_d;
  logic                 illegal_q, illegal_d;
  logic                 bus_err_q, bus_err_d;
  logic [MemCntW-1:0]   wait_q, wait_d;
  logic [CntW-1:0]      retired_q, retired_d;
  logic                 start;
  logic                 active;

  cpu_decoder u_decoder (
    .opcode_i  (opcode_i),
    .funct_i   (funct_i),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

`ifdef CPU_SEQ_STEP_EN
  logic step_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) step_q <= 1'b0;
    else         step_q <= step_i;
  end

  assign start = run_i | (step_i & ~step_q);
`else
  assign start = run_i;
`endif

  // DECODE shows the live decode; later phases replay the latched bundle.
  assign sel    = (state_q == StDecode) ? dec_ctrl : ctrl_q;
  assign active = (state_q == StDecode) || (state_q == StExec) ||
                  (state_q == StMem)    || (state_q == StWb);

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: state_d = StDecode;
      StDecode: begin
        ctrl_d = dec_ctrl;
        if (dec_illegal) begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        zero_d  = zero_i;
        wait_d  = '0;
        state_d = sel.mem ? StMem : StWb;
      end
      StMem: begin
        if (mem_ready_i) begin
          state_d = StWb;
        end else if (wait_q == MemCntW'(MemTimeout - 1)) begin
          state_d   = StHalt;
          bus_err_d = 1'b1;
        end else begin
          wait_d = wait_q + MemCntW'(1);
        end
      end
      StWb: begin
        retired_d = retired_q + CntW'(1);
        state_d   = run_i ? StFetch : StIdle;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      ctrl_q    <= CtrlNone;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    ri_o        = active & sel.ri;
    lw_o        = active & sel.lw;
    shift_o     = active & sel.shift;
    srl_o       = active & sel.srl;
    jal_o       = active & sel.jal;
    jr_o        = active & sel.jr;
    jjrjal_o    = active & sel.jjrjal;
    op_o        = active ? sel.op : AluAdd;
    write_reg_o = (state_q == StWb) & sel.wr_reg;
    write_mem_o = (state_q == StMem) & sel.store;
    jbeq_o      = (state_q == StWb) & ((sel.beq & zero_q) | (sel.bne & ~zero_q));
    pc_en_o     = (state_q == StWb);
    halted_o    = (state_q == StHalt);
    illegal_o   = illegal_q;
    bus_err_o   = bus_err_q;
    retired_o   = retired_q;
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: per-instruction vector table plus
// hand-written sequences for back-to-back execution, run drop and reset in MEM.
module tb_cpu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
`ifdef CPU_SEQ_STEP_EN
  logic        step = 1'b0;
`endif
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        jbeq, jjrjal, jal, jr, ri, lw, shift, srl;
  logic        write_reg, write_mem, pc_en, halted, illegal, bus_err;
  logic [2:0]  op;
  logic [31:0] retired;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_seq_ctrl #(
    .MemTimeout (16),
    .CntW       (32)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .run_i       (run),
`ifdef CPU_SEQ_STEP_EN
    .step_i      (step),
`endif
    .opcode_i    (opcode),
    .funct_i     (funct),
    .zero_i      (zero),
    .mem_ready_i (mem_ready),
    .jbeq_o      (jbeq),
    .jjrjal_o    (jjrjal),
    .jal_o       (jal),
    .jr_o        (jr),
    .ri_o        (ri),
    .lw_o        (lw),
    .shift_o     (shift),
    .srl_o       (srl),
    .write_reg_o (write_reg),
    .write_mem_o (write_mem),
    .op_o        (op),
    .pc_en_o     (pc_en),
    .halted_o    (halted),
    .illegal_o   (illegal),
    .bus_err_o   (bus_err),
    .retired_o   (retired)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        zero;
    int          rdy;    // MEM cycle (1-based) with mem_ready high, 0 = never
    logic [6:0]  sel;    // {ri, lw, shift, srl, jal, jr, jjrjal}
    logic [2:0]  op;
    int          pc;     // cycle of the pc_en pulse counted from FETCH = 1, 0 = none
    int          wr;
    int          wm;
    logic        jb;
    logic        hlt;
    logic        ill;
    logic        berr;
    int          ret;
  } vec_t;

  localparam int NumVec = 20;
  vec_t vecs[NumVec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] all_outs();
    return {jbeq, jjrjal, jal, jr, ri, lw, shift, srl, write_reg, write_mem, op,
            pc_en, halted, illegal, bus_err, 4'b0};
  endfunction

  task automatic do_reset();
    run       = 1'b0;
    mem_ready = 1'b0;
    zero      = 1'b0;
    opcode    = 6'd0;
    funct     = 6'd0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int pc_cyc, pc_cnt, wr_cyc, wr_cnt, wm_cnt;
    logic jb;
    pc_cyc = 0; pc_cnt = 0; wr_cyc = 0; wr_cnt = 0; wm_cnt = 0; jb = 1'b0;
    do_reset();
    opcode = v.instr[31:26];
    funct  = v.instr[5:0];
    zero   = v.zero;
    run    = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == 1) run = 1'b0;
      if (c == 2) check({v.name, " sel@decode"}, {22'd0, ri, lw, shift, srl, jal, jr, jjrjal, op},
                        {22'd0, v.sel, v.op});
      if (c == 3) check({v.name, " sel@exec"}, {22'd0, ri, lw, shift, srl, jal, jr, jjrjal, op},
                        {22'd0, (v.ill ? 7'd0 : v.sel), (v.ill ? 3'd0 : v.op)});
      if (pc_en) begin
        pc_cnt++;
        if (pc_cyc == 0) pc_cyc = c;
      end
      if (write_reg) begin
        wr_cnt++;
        if (wr_cyc == 0) wr_cyc = c;
      end
      if (write_mem) wm_cnt++;
      jb = jb | jbeq;
      mem_ready = (v.rdy != 0) && (c == 3 + v.rdy);
    end
    check({v.name, " pc_en cycle"}, pc_cyc, v.pc);
    check({v.name, " pc_en pulses"}, pc_cnt, (v.pc != 0) ? 1 : 0);
    check({v.name, " writeReg count"}, wr_cnt, v.wr);
    check({v.name, " writeReg cycle"}, wr_cyc, (v.wr != 0) ? v.pc : 0);
    check({v.name, " writeMem count"}, wm_cnt, v.wm);
    check({v.name, " JBEQ"}, {31'd0, jb}, {31'd0, v.jb});
    check({v.name, " halted/illegal/bus_err"}, {29'd0, halted, illegal, bus_err},
          {29'd0, v.hlt, v.ill, v.berr});
    check({v.name, " retired"}, retired, v.ret);
  endtask

  initial begin
    //          name        instr         z  rdy sel          op      pc wr wm  jb hlt ill berr ret
    vecs[0]  = '{"addi",    32'h20010005, 0, 0, 7'b1000000, 3'b000, 4, 1, 0,  0, 0, 0, 0, 1};
    vecs[1]  = '{"lw",      32'h8C220004, 0, 3, 7'b1100000, 3'b000, 7, 1, 0,  0, 0, 0, 0, 1};
    vecs[2]  = '{"sw_tmo",  32'hAC220004, 0, 0, 7'b1000000, 3'b000, 0, 0, 16, 0, 1, 0, 1, 0};
    vecs[3]  = '{"sw",      32'hAC220004, 0, 1, 7'b1000000, 3'b000, 5, 0, 1,  0, 0, 0, 0, 1};
    vecs[4]  = '{"beq_z1",  32'h10220003, 1, 0, 7'b0000000, 3'b001, 4, 0, 0,  1, 0, 0, 0, 1};
    vecs[5]  = '{"bne_z1",  32'h14220003, 1, 0, 7'b0000000, 3'b001, 4, 0, 0,  0, 0, 0, 0, 1};
    vecs[6]  = '{"bne_z0",  32'h14220003, 0, 0, 7'b0000000, 3'b001, 4, 0, 0,  1, 0, 0, 0, 1};
    vecs[7]  = '{"beq_z0",  32'h10220003, 0, 0, 7'b0000000, 3'b001, 4, 0, 0,  0, 0, 0, 0, 1};
    vecs[8]  = '{"op3f",    32'hFC000000, 0, 0, 7'b0000000, 3'b000, 0, 0, 0,  0, 1, 1, 0, 0};
    vecs[9]  = '{"add",     32'h00221820, 0, 0, 7'b0000000, 3'b000, 4, 1, 0,  0, 0, 0, 0, 1};
    vecs[10] = '{"sub",     32'h00221822, 0, 0, 7'b0000000, 3'b001, 4, 1, 0,  0, 0, 0, 0, 1};
    vecs[11] = '{"and",     32'h00221824, 0, 0, 7'b0000000, 3'b010, 4, 1, 0,  0, 0, 0, 0, 1};
    vecs[12] = '{"or",      32'h00221825, 0, 0, 7'b0000000, 3'b011, 4, 1, 0,  0, 0, 0, 0, 1};
    vecs[13] = '{"slt",     32'h0022182A, 0, 0, 7'b0000000, 3'b100, 4, 1, 0,  0, 0, 0, 0, 1};
    vecs[14] = '{"sll",     32'h00021840, 0, 0, 7'b0010000, 3'b000, 4, 1, 0,  0, 0, 0, 0, 1};
    vecs[15] = '{"srl",     32'h00021842, 0, 0, 7'b0011000, 3'b000, 4, 1, 0,  0, 0, 0, 0, 1};
    vecs[16] = '{"jr",      32'h00200008, 0, 0, 7'b0000011, 3'b000, 4, 0, 0,  0, 0, 0, 0, 1};
    vecs[17] = '{"jal",     32'h0C000010, 0, 0, 7'b0000101, 3'b000, 4, 1, 0,  0, 0, 0, 0, 1};
    vecs[18] = '{"ori",     32'h34220001, 0, 0, 7'b1000000, 3'b011, 4, 1, 0,  0, 0, 0, 0, 1};
    vecs[19] = '{"rfn3f",   32'h0000003F, 0, 0, 7'b0000000, 3'b000, 0, 0, 0,  0, 1, 1, 0, 0};

    // Reset state.
    do_reset();
    check("reset outputs", {11'd0, all_outs()}, 32'd0);
    check("reset retired", retired, 32'd0);

    for (int i = 0; i < NumVec; i++) run_vec(vecs[i]);

    // Back-to-back addi with run held, then run dropped in EXEC of the third.
    begin
      int pc_cnt, wr_cnt;
      int pcs[3];
      pc_cnt = 0; wr_cnt = 0;
      pcs[0] = 0; pcs[1] = 0; pcs[2] = 0;
      do_reset();
      opcode = 6'b001000;
      funct  = 6'd5;
      run    = 1'b1;
      for (int c = 1; c <= 20; c++) begin
        tick();
        if (c == 11) run = 1'b0;
        if (pc_en) begin
          if (pc_cnt < 3) pcs[pc_cnt] = c;
          pc_cnt++;
        end
        if (write_reg) wr_cnt++;
      end
      check("b2b pc_en pulses", pc_cnt, 3);
      check("b2b pc_en cycle 1", pcs[0], 4);
      check("b2b pc_en cycle 2", pcs[1], 8);
      check("b2b pc_en cycle 3", pcs[2], 12);
      check("b2b writeReg count", wr_cnt, 3);
      check("b2b retired", retired, 3);
      check("b2b idle outputs", {11'd0, all_outs()}, 32'd0);
    end

    // Asynchronous reset in the middle of a sw MEM wait.
    do_reset();
    opcode = 6'b101011;
    funct  = 6'd4;
    run    = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) run = 1'b0;
    end
    check("mem wait writeMem", {31'd0, write_mem}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset in MEM outputs", {11'd0, all_outs()}, 32'd0);
    check("reset in MEM retired", retired, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("after reset idle", {11'd0, all_outs()}, 32'd0);

`ifdef CPU_SEQ_STEP_EN
    begin
      int pc_cnt;
      pc_cnt = 0;
      do_reset();
      opcode = 6'b001000;
      funct  = 6'd5;
      tick();
      step = 1'b1;
      for (int c = 1; c <= 12; c++) begin
        tick();
        if (pc_en) pc_cnt++;
      end
      step = 1'b0;
      check("step pc_en pulses", pc_cnt, 1);
      check("step retired", retired, 1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
